// File: rtl/multi_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : multi_debouncer
// Description : Multi-channel switch/button debouncer. Each channel passes
//               through a two-flop synchroniser. A new level is accepted
//               only after it has been stable for STABLE cycles. The block
//               debounces both press and release, and emits one-cycle
//               rise/fall pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_debouncer #(
  parameter int              CH         = 4,
  parameter int              STABLE     = 10,
  parameter int              CNT_W      = 4,
  parameter logic [CH-1:0]   ACTIVE_LOW = {CH{1'b0}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] noisy,
  output logic [CH-1:0] debounced,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall
);

  // Terminal count: the last disagreeing sample before a level is accepted.
  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(STABLE - 1);

  // Reject configurations where the counter cannot reach STABLE-1.
  if (STABLE < 1 || (2 ** CNT_W) < STABLE) begin : g_param_check
    $error("multi_debouncer: need STABLE >= 1 and 2**CNT_W >= STABLE");
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic             sync1_q;
    logic             sync2_q;
    logic             db_q;
    logic             db_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next state. Any sample that agrees with the accepted level clears the
    // partial count, so a glitch shorter than STABLE never reaches the output.
    always_comb begin
      db_d   = db_q;
      cnt_d  = '0;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (sync2_q != db_q) begin
        if (cnt_q == c_last_cnt) begin
          db_d   = sync2_q;
          rise_d = sync2_q;
          fall_d = ~sync2_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    // Synchroniser, counter, accepted level and edge pulses. Polarity is
    // corrected before the first flop, so idle-high inputs look idle-low.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        cnt_q   <= '0;
        db_q    <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        sync1_q <= noisy[i] ^ ACTIVE_LOW[i];
        sync2_q <= sync1_q;
        cnt_q   <= cnt_d;
        db_q    <= db_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    assign debounced[i] = db_q;
    assign rise[i]      = rise_q;
    assign fall[i]      = fall_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_debouncer
// Description : Self-checking bench for multi_debouncer (CH=4, STABLE=4,
//               CNT_W=3, ACTIVE_LOW=4'b1000). A reference model pushes the
//               expected outputs for every edge into a queue. Each scenario
//               task pops one entry per cycle and compares it. Each task also
//               checks hand-derived event timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_debouncer;

  localparam int         c_ch     = 4;
  localparam int         c_stable = 4;
  localparam logic [3:0] c_al     = 4'b1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] noisy = 4'b1000;
  logic [3:0] debounced;
  logic [3:0] rise;
  logic [3:0] fall;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] db;
    logic [3:0] r;
    logic [3:0] f;
  } exp_t;

  exp_t exp_q[$];

  multi_debouncer #(
    .CH        (c_ch),
    .STABLE    (c_stable),
    .CNT_W     (3),
    .ACTIVE_LOW(c_al)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .noisy    (noisy),
    .debounced(debounced),
    .rise     (rise),
    .fall     (fall)
  );

  always #5 clk = ~clk;

  // Reference model. After each edge it pushes the outputs expected to be
  // visible. A level is accepted once the synchronised sample has disagreed
  // with the accepted level on c_stable consecutive edges.
  initial begin : model
    logic [3:0] m_s1;
    logic [3:0] m_s2;
    logic [3:0] m_db;
    logic [3:0] m_r;
    logic [3:0] m_f;
    int         m_run[4];
    exp_t       e;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_s1 = '0; m_s2 = '0; m_db = '0; m_r = '0; m_f = '0;
        for (int c = 0; c < 4; c++) m_run[c] = 0;
      end else begin
        for (int c = 0; c < 4; c++) begin
          m_r[c] = 1'b0;
          m_f[c] = 1'b0;
          if (m_s2[c] != m_db[c]) begin
            m_run[c] = m_run[c] + 1;
            if (m_run[c] == c_stable) begin
              m_db[c]  = m_s2[c];
              m_r[c]   = m_s2[c];
              m_f[c]   = ~m_s2[c];
              m_run[c] = 0;
            end
          end else begin
            m_run[c] = 0;
          end
        end
        m_s2 = m_s1;
        m_s1 = noisy ^ c_al;
      end
      e.db = m_db; e.r = m_r; e.f = m_f;
      exp_q.push_back(e);
    end
  end

  // Advance one edge and settle past it; inputs change here, away from edges.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst   = 1'b1;
    noisy = 4'b1000;
    for (int j = 0; j < 3; j++) begin
      tick();
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      checks++;
      if ({debounced, rise, fall} !== 12'h000) begin
        errors++;
        $display("FAIL reset_hold j=%0d actual=%b required=%b", j, {debounced, rise, fall}, 12'h000);
      end
      checks++;
      if ({debounced, rise, fall} !== e) begin
        errors++;
        $display("FAIL reset_sb j=%0d actual=%b required=%b", j, {debounced, rise, fall}, e);
      end
    end
    rst = 1'b0;
    for (int j = 0; j < 20; j++) begin
      tick();
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      checks++;
      if ({debounced, rise, fall} !== 12'h000 || {debounced, rise, fall} !== e) begin
        errors++;
        $display("FAIL reset_idle j=%0d actual=%b required=%b", j, {debounced, rise, fall}, e);
      end
    end
  endtask

  task automatic test_clean_press();
    exp_t e;
    noisy[0] = 1'b1;
    for (int j = 0; j < 9; j++) begin
      tick();  // edge k+j
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      checks++;
      if ({debounced, rise, fall} !== e) begin
        errors++;
        $display("FAIL press_sb j=%0d actual=%b required=%b", j, {debounced, rise, fall}, e);
      end
      checks++;
      if (rise[0] !== (j == 5) || debounced[0] !== (j >= 5) ||
          debounced[3:1] !== 3'b000 || fall !== 4'b0000 || rise[3:1] !== 3'b000) begin
        errors++;
        $display("FAIL press_timing j=%0d actual db=%b r=%b f=%b required db0=%0d r0=%0d",
                 j, debounced, rise, fall, (j >= 5), (j == 5));
      end
    end
  endtask

  task automatic test_glitch();
    exp_t e;
    for (int rep = 0; rep < 10; rep++) begin
      for (int p = 0; p < 4; p++) begin
        noisy[1] = (p < 3);
        tick();
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        checks++;
        if ({debounced, rise, fall} !== e || debounced[1] !== 1'b0 ||
            rise[1] !== 1'b0 || fall[1] !== 1'b0) begin
          errors++;
          $display("FAIL glitch_reject rep=%0d p=%0d actual=%b required=%b db1=0",
                   rep, p, {debounced, rise, fall}, e);
        end
      end
    end
    noisy[1] = 1'b1;
    for (int j = 0; j < 8; j++) begin
      tick();
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      checks++;
      if ({debounced, rise, fall} !== e) begin
        errors++;
        $display("FAIL glitch_sb j=%0d actual=%b required=%b", j, {debounced, rise, fall}, e);
      end
      checks++;
      if (rise[1] !== (j == 5) || debounced[1] !== (j >= 5)) begin
        errors++;
        $display("FAIL glitch_accept j=%0d actual db1=%b r1=%b required db1=%0d r1=%0d",
                 j, debounced[1], rise[1], (j >= 5), (j == 5));
      end
    end
  endtask

  task automatic test_active_low_release();
    exp_t e;
    for (int phase = 0; phase < 2; phase++) begin
      noisy[3] = (phase == 1);  // 0 = pressed on an idle-high channel
      for (int j = 0; j < 8; j++) begin
        tick();
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        checks++;
        if ({debounced, rise, fall} !== e) begin
          errors++;
          $display("FAIL al_sb phase=%0d j=%0d actual=%b required=%b",
                   phase, j, {debounced, rise, fall}, e);
        end
        checks++;
        if (phase == 0 && (rise[3] !== (j == 5) || fall[3] !== 1'b0 || debounced[3] !== (j >= 5))) begin
          errors++;
          $display("FAIL al_press j=%0d actual db3=%b r3=%b f3=%b required db3=%0d r3=%0d f3=0",
                   j, debounced[3], rise[3], fall[3], (j >= 5), (j == 5));
        end else if (phase == 1 && (fall[3] !== (j == 5) || rise[3] !== 1'b0 || debounced[3] !== (j < 5))) begin
          errors++;
          $display("FAIL al_release j=%0d actual db3=%b r3=%b f3=%b required db3=%0d r3=0 f3=%0d",
                   j, debounced[3], rise[3], fall[3], (j < 5), (j == 5));
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    // Setup: ch0 back to 0, ch2 accepted high.
    noisy[0] = 1'b0;
    noisy[2] = 1'b1;
    for (int j = 0; j < 8; j++) begin
      tick();
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      checks++;
      if ({debounced, rise, fall} !== e) begin
        errors++;
        $display("FAIL simul_setup_sb j=%0d actual=%b required=%b", j, {debounced, rise, fall}, e);
      end
    end
    checks++;
    if (debounced[0] !== 1'b0 || debounced[2] !== 1'b1) begin
      errors++;
      $display("FAIL simul_setup_level actual db=%b required db0=0 db2=1", debounced);
    end
    noisy[0] = 1'b1;
    noisy[2] = 1'b0;
    for (int j = 0; j < 8; j++) begin
      tick();
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      checks++;
      if ({debounced, rise, fall} !== e) begin
        errors++;
        $display("FAIL simul_sb j=%0d actual=%b required=%b", j, {debounced, rise, fall}, e);
      end
      checks++;
      if (rise[0] !== (j == 5) || fall[2] !== (j == 5) || rise[2] !== 1'b0 || fall[0] !== 1'b0) begin
        errors++;
        $display("FAIL simul_pulse j=%0d actual r=%b f=%b required r0=f2=%0d", j, rise, fall, (j == 5));
      end
    end
  endtask

  task automatic test_reset_mid_count();
    exp_t e;
    noisy[0] = 1'b0;
    for (int j = 0; j < 8; j++) begin
      tick();
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      checks++;
      if ({debounced, rise, fall} !== e) begin
        errors++;
        $display("FAIL rmc_setup_sb j=%0d actual=%b required=%b", j, {debounced, rise, fall}, e);
      end
    end
    noisy[0] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      checks++;
      if ({debounced, rise, fall} !== e || debounced[0] !== 1'b0) begin
        errors++;
        $display("FAIL rmc_count_sb j=%0d actual=%b required=%b", j, {debounced, rise, fall}, e);
      end
    end
    rst = 1'b1;
    tick();
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
    checks++;
    if ({debounced, rise, fall} !== 12'h000 || e !== 12'h000) begin
      errors++;
      $display("FAIL rmc_reset_edge actual=%b model=%b required=%b", {debounced, rise, fall}, e, 12'h000);
    end
    rst = 1'b0;
    // j counts edges after the reset edge; the first is where x is resampled.
    for (int j = 1; j <= 9; j++) begin
      tick();
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      checks++;
      if ({debounced, rise, fall} !== e) begin
        errors++;
        $display("FAIL rmc_sb j=%0d actual=%b required=%b", j, {debounced, rise, fall}, e);
      end
      checks++;
      if (debounced[0] !== (j >= 6) || rise[0] !== (j == 6)) begin
        errors++;
        $display("FAIL rmc_restart j=%0d actual db0=%b r0=%b required db0=%0d r0=%0d",
                 j, debounced[0], rise[0], (j >= 6), (j == 6));
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_active_low_release();
    test_simultaneous();
    test_reset_mid_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_debouncer.md
# multi_debouncer

Parametrised multi-channel debouncer for mechanical switch and button inputs. Each channel synchronises its raw asynchronous input and declares a level change only after the new level has been stable for a programmable number of clock cycles. It debounces both press and release and emits one-cycle rise/fall pulses. It sits between board-level pins and control FSMs, and replaces single-channel, press-only debouncing with a saturating-free, symmetric scheme.

## Interface

Parameters:
- CH, 4: number of independent channels (≥1).
- STABLE, 10: consecutive stable cycles required to accept a new level (≥1).
- CNT_W, 4: per-channel counter width; must satisfy 2^CNT_W ≥ STABLE.
- ACTIVE_LOW, {CH{1'b0}}: per-channel mask; bit=1 inverts that channel's raw input before synchronisation (idle-high buttons).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- noisy  input  CH  raw asynchronous switch levels.
- debounced  output  CH  accepted (debounced) logical level per channel.
- rise  output  CH  one-cycle pulse when debounced bit goes 0→1.
- fall  output  CH  one-cycle pulse when debounced bit goes 1→0.

## Operation

- Per channel i: x = noisy[i] ^ ACTIVE_LOW[i]; two-flop synchroniser sync1 <= x, sync2 <= sync1; s = sync2.
- Counter cnt[i] (CNT_W bits), state db[i] = debounced[i]. Every clock:
  - s == db: cnt <= 0; rise/fall <= 0.
  - s != db and cnt == STABLE-1: db <= s; cnt <= 0; rise <= s; fall <= ~s.
  - s != db otherwise: cnt <= cnt+1; rise/fall <= 0.
- Any cycle with s == db before reaching STABLE-1 discards the partial count (glitch rejected, no event).
- Counter never exceeds STABLE-1, so it never wraps. No free-running count.
- Channels are fully independent; any number may change and pulse in the same cycle.
- rise and fall for one channel are never both high. A pulse is never produced without a matching debounced transition.
- Reset (rst=1 at an edge): sync1, sync2, cnt, debounced, rise, fall all 0 for every channel. Reset mid-count discards the count. Reset during a pulse cycle deasserts it at that edge.
- Because of the ACTIVE_LOW inversion, an idle-high input produces no event after reset.
- Elaboration must fail, or assert in simulation, if STABLE < 1 or 2^CNT_W < STABLE.

## Timing

- All outputs are registered; no combinational path from noisy to any output.
- Latency: if x has its new value when sampled at edge k and holds it, db updates at edge k+STABLE+1. The rise/fall pulse is high in the cycle following that same edge, for exactly one cycle.
- Minimum accepted pulse width on x: STABLE cycles as seen at s. Shorter disturbances produce no output change.
- Sustained chatter with period below STABLE cycles never changes debounced.
- Release is symmetric with press: same STABLE+1-edge latency after the synchroniser.
- STABLE=1: a change is accepted the first cycle s differs (2 edges after sampling).

## Test plan

Bench configuration: CH=4, STABLE=4, CNT_W=3, ACTIVE_LOW=4'b1000.

- Reset: hold rst 3 cycles with noisy=4'b1000 → debounced=0, rise=0, fall=0 throughout. After release, no pulses for 20 cycles.
- Clean press ch0: noisy[0] 0→1 sampled at edge k and held → debounced[0]=1 after edge k+5; rise[0]=1 for exactly one cycle; other channels unchanged.
- Glitch rejection ch1: noisy[1] high for 3 cycles, low 1 cycle, repeated 10 times → debounced[1] stays 0, no rise/fall. Then hold high 4+ cycles → accepted with latency 5 edges.
- Release and active-low ch3: drive noisy[3]=0 (pressed) and hold → rise[3] after 5 edges. Return to 1 → fall[3] pulse and debounced[3]=0 after 5 edges.
- Simultaneous: ch0 and ch2 change on the same edge, ch0 0→1 and ch2 1→0 from a debounced-high state → rise[0] and fall[2] pulse in the same cycle.
- Reset mid-count: ch0 high for 3 cycles, then rst=1 one cycle, input still high → counter restarts. Acceptance occurs 5 edges after rst deasserts, not earlier.
